// File: rtl/sec_cnt.sv
// sec_cnt: seconds stage of the digital clock; 1 Hz prescaler, 0..59 counter,
// set mode with a synchronised increment button and a registered minute clock.
module sec_cnt #(
  parameter int DIV = 50000000,
  parameter int PW  = 26
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_btn,
  input  logic       clr,
  output logic [5:0] sec_out,
  output logic       sec_tick,
  output logic       min_clk
);
  typedef enum logic [1:0] {PAUSE, RUN, SET} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0] sec_q, sec_d, sec_nxt;
  logic tick_q, tick_d, min_q, min_d;
  logic [2:0] btn_q;
  logic inc_pulse, wrap;
  always_ff @(posedge inclk or negedge rst)
    if (!rst) state_q <= PAUSE;
    else state_q <= state_d;
  always_comb state_d = set_mode ? SET : run ? RUN : PAUSE;
  // btn_q[1:0] is the two-flop synchroniser, btn_q[2] the edge-detect history
  assign inc_pulse = btn_q[1] & ~btn_q[2];
  assign wrap = (state_q == RUN) && (pre_q == PW'(DIV - 1));
  assign sec_nxt = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
  always_comb begin
    pre_d = (state_q == SET) ? '0 : (state_q == RUN) ? (wrap ? '0 : pre_q + PW'(1)) : pre_q;
    sec_d = (wrap || (state_q == SET && inc_pulse)) ? sec_nxt : sec_q;
    tick_d = wrap;
    min_d = wrap ? ((sec_q == 6'd59) ? 1'b1 : (sec_nxt >= 6'd30) ? 1'b0 : min_q) : min_q;
    if (clr) begin
      pre_d = '0;
      sec_d = '0;
      tick_d = 1'b0;
      min_d = 1'b0;
    end
  end
  always_ff @(posedge inclk or negedge rst)
    if (!rst) begin
      pre_q <= '0;
      sec_q <= '0;
      tick_q <= 1'b0;
      min_q <= 1'b0;
      btn_q <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
      tick_q <= tick_d;
      min_q <= min_d;
      btn_q <= {btn_q[1:0], inc_btn};
    end
  always_comb begin
    sec_out = sec_q;
    sec_tick = tick_q;
    min_clk = min_q;
  end
endmodule

// File: tb/tb_sec_cnt.sv
// tb_sec_cnt: random and directed stimulus for sec_cnt, checked by a queue-based
// scoreboard fed from a behavioural model of the seconds counter.
module tb_sec_cnt;
  localparam int DIV = 4;
  logic inclk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0, set_mode = 1'b0, inc_btn = 1'b0, clr = 1'b0;
  logic [5:0] sec_out;
  logic sec_tick, min_clk;
  int checks = 0, fails = 0, cyc = 0;
  logic [7:0] q[$];
  int m_sec = 0, m_pre = 0, m_mode = 0;
  bit m_tick = 0, m_min = 0;
  bit [2:0] hist = '0;

  sec_cnt #(.DIV(DIV), .PW(3)) dut (
    .inclk(inclk), .rst(rst), .run(run), .set_mode(set_mode), .inc_btn(inc_btn),
    .clr(clr), .sec_out(sec_out), .sec_tick(sec_tick), .min_clk(min_clk)
  );

  always #5 inclk = ~inclk;

  // mode: 0 pause, 1 run, 2 set; hist holds inc_btn as sampled on the last three edges
  always @(posedge inclk) begin
    bit pulse;
    cyc++;
    pulse = hist[1] && !hist[2];
    if (!rst) begin
      m_sec = 0; m_pre = 0; m_mode = 0; m_tick = 0; m_min = 0; hist = '0;
    end else begin
      m_tick = 0;
      if (clr) begin
        m_sec = 0; m_pre = 0; m_min = 0;
      end else if (m_mode == 1) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_sec = (m_sec + 1) % 60;
          m_tick = 1;
          if (m_sec == 0) m_min = 1;
          else if (m_sec >= 30) m_min = 0;
        end else m_pre++;
      end else if (m_mode == 2) begin
        m_pre = 0;
        if (pulse) m_sec = (m_sec + 1) % 60;
      end
      m_mode = set_mode ? 2 : run ? 1 : 0;
      hist = {hist[1:0], inc_btn};
    end
    q.push_back({6'(m_sec), m_tick, m_min});
  end

  initial begin
    logic rp;
    logic [7:0] e;
    rp = 1'b0;
    forever begin
      @(negedge inclk or negedge rst);
      if (rp && !rst) begin
        #1;
        checks++;
        if ({sec_out, sec_tick, min_clk} !== 8'd0) begin
          fails++;
          $display("FAIL async_reset t=%0t got sec=%0d tick=%0b min=%0b want all 0", $time, sec_out, sec_tick, min_clk);
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({sec_out, sec_tick, min_clk} !== e) begin
          fails++;
          $display("FAIL outputs cyc=%0d got sec=%0d tick=%0b min=%0b want sec=%0d tick=%0b min=%0b",
                   cyc, sec_out, sec_tick, min_clk, e[7:2], e[1], e[0]);
        end
      end
      rp = rst;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge inclk);
      #1;
    end
  endtask

  task automatic run_to(input int s);
    int g = 0;
    while (!(m_sec == s && m_pre == DIV - 1 && m_mode == 1)) begin
      step(1);
      if (++g > 2000) begin
        $display("FAIL run_to timeout waiting for sec=%0d", s);
        $fatal(1);
      end
    end
  endtask

  initial begin
    step(3);
    rst = 1'b1;
    run = 1'b1;
    step(500);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(10);
    run = 1'b0;
    step(50);
    run = 1'b1;
    step(10);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    set_mode = 1'b1;
    for (int i = 0; i < 61; i++) begin
      inc_btn = 1'b1;
      step(8);
      inc_btn = 1'b0;
      step(8);
    end
    set_mode = 1'b0;
    run = 1'b0;
    step(4);
    inc_btn = 1'b1;
    step(8);
    inc_btn = 1'b0;
    step(8);
    run = 1'b1;
    run_to(45);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(8);
    run_to(59);
    step(1);
    @(posedge inclk);
    #7 rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(12);
    set_mode = 1'b1;
    step(20);
    set_mode = 1'b0;
    step(10);
    for (int s = 0; s < 200; s++) begin
      int len;
      len = $urandom_range(1, 30);
      run = ($urandom % 4) != 0;
      set_mode = ($urandom % 6) == 0;
      for (int c = 0; c < len; c++) begin
        if ($urandom % 3 == 0) inc_btn = ~inc_btn;
        clr = ($urandom % 50) == 0;
        step(1);
      end
    end
    clr = 1'b0;
    step(3);
    @(negedge inclk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
